// File: rtl/tree_link_pkg.sv
// tree_link_pkg -- shared encodings for the 1:N link router.
// Rev 1.0
`default_nettype none

package tree_link_pkg;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  // Encoding doubles as the link_state debug value.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } link_state_t;

  function automatic logic cmd_valid(input logic [2:0] cmd);
    return (cmd == MCMD_WR) || (cmd == MCMD_RD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tree_link_tmo.sv
// tree_link_tmo -- per-transaction timeout counter for the link router.
// Rev 1.0
`default_nettype none

module tree_link_tmo #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Room for TMO_CYC+1: an accept on the limit cycle moves one count past it.
  localparam int CNT_W = ($clog2(TMO_CYC + 2) > 8) ? $clog2(TMO_CYC + 2) : 8;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt >= CNT_W'(TMO_CYC));

endmodule

`default_nettype wire

// File: rtl/tree_link_n.sv
// tree_link_n -- 1:N OCP-style command/response router with decode, ERR for unmapped
// slaves and a per-transaction timeout. Rev 1.0
`default_nettype none

module tree_link_n
  import tree_link_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int TMO_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                m_MCmd,
  input  logic [ADDR_W-1:0]         m_MAddr,
  input  logic [DATA_W-1:0]         m_MData,
  output logic                      m_SCmdAccept,
  output logic [DATA_W-1:0]         m_SData,
  output logic [1:0]                m_SResp,
  input  logic                      m_MRespAccept,
  output logic [3*NUM_SLV-1:0]      s_MCmd,
  output logic [ADDR_W*NUM_SLV-1:0] s_MAddr,
  output logic [DATA_W*NUM_SLV-1:0] s_MData,
  input  logic [NUM_SLV-1:0]        s_SCmdAccept,
  input  logic [DATA_W*NUM_SLV-1:0] s_SData,
  input  logic [2*NUM_SLV-1:0]      s_SResp,
  output logic [NUM_SLV-1:0]        s_MRespAccept,
  output logic [SEL_W:0]            active_link,
  output logic [1:0]                link_state,
  output logic                      tmo_flag
);

  link_state_t       state;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              mapped;

  logic [SEL_W-1:0]  m_sel;
  logic              map_ok;
  logic              sel_accept;
  logic [1:0]        sel_resp;
  logic [DATA_W-1:0] sel_data;
  logic              tmo_en;
  logic              tmo_clr;
  logic              tmo_expired;

  assign m_sel        = m_MAddr[ADDR_W-1 -: SEL_W];
  assign map_ok       = cmd_valid(m_MCmd) && ({1'b0, m_sel} < (SEL_W+1)'(NUM_SLV));
  assign m_SCmdAccept = rst_n && (state == ST_IDLE) && (m_MCmd != MCMD_IDLE);

  always_comb begin
    sel_accept = 1'b0;
    sel_resp   = SRESP_NULL;
    sel_data   = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_accept = s_SCmdAccept[k];
        sel_resp   = s_SResp[2*k +: 2];
        sel_data   = s_SData[DATA_W*k +: DATA_W];
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
      logic drive;
      assign drive = (state == ST_CMD) && (sel_q == SEL_W'(k));
      assign s_MCmd[3*k +: 3]               = drive ? cmd_q  : MCMD_IDLE;
      assign s_MAddr[ADDR_W*k +: ADDR_W]    = drive ? addr_q : '0;
      assign s_MData[DATA_W*k +: DATA_W]    = drive ? data_q : '0;
      assign s_MRespAccept[k] = rst_n && (state == ST_WAIT) && (sel_q == SEL_W'(k))
                                && (s_SResp[2*k +: 2] != SRESP_NULL);
    end
  endgenerate

  assign tmo_en  = (state == ST_CMD) || (state == ST_WAIT);
  assign tmo_clr = m_SCmdAccept && map_ok;

  tree_link_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign link_state  = state;
  assign active_link = (mapped && state != ST_IDLE) ? ({1'b0, sel_q} + (SEL_W+1)'(1)) : '0;

  // Slave accept/response is checked before expiry so it wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= MCMD_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      mapped   <= 1'b0;
      m_SResp  <= SRESP_NULL;
      m_SData  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_SCmdAccept) begin
            cmd_q  <= m_MCmd;
            addr_q <= m_MAddr;
            data_q <= m_MData;
            sel_q  <= m_sel;
            mapped <= map_ok;
            if (map_ok) begin
              state <= ST_CMD;
            end else begin
              state   <= ST_RESP;
              m_SResp <= SRESP_ERR;
              m_SData <= '0;
            end
          end
        end
        ST_CMD: begin
          if (sel_accept) begin
            state <= ST_WAIT;
          end else if (tmo_expired) begin
            state    <= ST_RESP;
            m_SResp  <= SRESP_ERR;
            m_SData  <= '0;
            tmo_flag <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (sel_resp != SRESP_NULL) begin
            state   <= ST_RESP;
            m_SResp <= sel_resp;
            m_SData <= sel_data;
          end else if (tmo_expired) begin
            state    <= ST_RESP;
            m_SResp  <= SRESP_ERR;
            m_SData  <= '0;
            tmo_flag <= 1'b1;
          end
        end
        ST_RESP: begin
          if (m_MRespAccept) begin
            state   <= ST_IDLE;
            mapped  <= 1'b0;
            m_SResp <= SRESP_NULL;
            m_SData <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tree_link_n.sv
// tb_tree_link_n -- self-checking bench for tree_link_n (3 slaves, 8-cycle timeout).
`default_nettype none

module tb_tree_link_n;

  localparam int NS  = 3;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       m_MCmd;
  logic [AW-1:0]    m_MAddr;
  logic [DW-1:0]    m_MData;
  logic             m_SCmdAccept;
  logic [DW-1:0]    m_SData;
  logic [1:0]       m_SResp;
  logic             m_MRespAccept;
  logic [3*NS-1:0]  s_MCmd;
  logic [AW*NS-1:0] s_MAddr;
  logic [DW*NS-1:0] s_MData;
  logic [NS-1:0]    s_SCmdAccept;
  logic [DW*NS-1:0] s_SData;
  logic [2*NS-1:0]  s_SResp;
  logic [NS-1:0]    s_MRespAccept;
  logic [SW:0]      active_link;
  logic [1:0]       link_state;
  logic             tmo_flag;

  tree_link_n #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_MCmd(m_MCmd), .m_MAddr(m_MAddr), .m_MData(m_MData),
    .m_SCmdAccept(m_SCmdAccept), .m_SData(m_SData), .m_SResp(m_SResp),
    .m_MRespAccept(m_MRespAccept),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData),
    .s_SCmdAccept(s_SCmdAccept), .s_SData(s_SData), .s_SResp(s_SResp),
    .s_MRespAccept(s_MRespAccept),
    .active_link(active_link), .link_state(link_state), .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic tmo_exp = 1'b0;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    int         a;       // cycles the slave waits in CMD before accepting
    int         r;       // cycles the slave waits in WAIT before responding
    logic [1:0] sresp;
    logic [7:0] sdata;
    int         h;       // cycles the master holds off MRespAccept
    bit         pester;  // master keeps MCmd asserted during the transaction
    logic [1:0] exp_resp;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [2:0] c, logic [7:0] ad, logic [7:0] da, int a, int r,
                              logic [1:0] sr, logic [7:0] sd, int h, bit p,
                              logic [1:0] er, logic [7:0] ed);
    vec_t v;
    v.cmd = c; v.addr = ad; v.data = da; v.a = a; v.r = r; v.sresp = sr; v.sdata = sd;
    v.h = h; v.pester = p; v.exp_resp = er; v.exp_data = ed;
    return v;
  endfunction

  // Transaction-level prediction: relative cycle (command accept = 0) at which the
  // response appears on the master port, and what it carries.
  task automatic model(input vec_t v, output bit mapped, output bit acc, output bit tmo,
                       output int rc, output logic [1:0] resp, output logic [7:0] d);
    int sel = int'(v.addr[7:6]);
    int rcyc, tcyc;
    mapped = (v.cmd == 3'd1 || v.cmd == 3'd2) && sel < NS;
    acc = 1'b0; tmo = 1'b0; resp = 2'b11; d = 8'h00;
    if (!mapped) begin
      rc = 1;
    end else if (v.a > TMO) begin
      tmo = 1'b1;
      rc  = TMO + 2;
    end else begin
      acc  = 1'b1;
      rcyc = 2 + v.a + v.r;
      tcyc = (1 + TMO > 2 + v.a) ? 1 + TMO : 2 + v.a;
      if (rcyc <= tcyc) begin
        rc = rcyc + 1; resp = v.sresp; d = v.sdata;
      end else begin
        tmo = 1'b1;
        rc  = tcyc + 1;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " accept"}, 32'(m_SCmdAccept), 0);
    chk({tag, " state"},  32'(link_state), 0);
    chk({tag, " link"},   32'(active_link), 0);
    chk({tag, " s_cmd"},  32'(s_MCmd), 0);
    chk({tag, " s_racc"}, 32'(s_MRespAccept), 0);
    chk({tag, " m_resp"}, 32'(m_SResp), 0);
    chk({tag, " m_data"}, 32'(m_SData), 0);
    chk({tag, " tmo"},    32'(tmo_flag), 32'(tmo_exp));
  endtask

  task automatic zero_inputs();
    m_MCmd = 3'd0; m_MAddr = '0; m_MData = '0; m_MRespAccept = 1'b0;
    s_SCmdAccept = '0; s_SData = '0; s_SResp = '0;
  endtask

  task automatic run_txn(input vec_t v, input logic [1:0] er, input logic [7:0] ed);
    bit mapped, acc, tmo, resp_taken;
    int rc, end_c, last_cmd;
    int sel = int'(v.addr[7:6]);
    logic [1:0] mr;
    logic [7:0] md;
    logic [3*NS-1:0]  e_cmd;
    logic [AW*NS-1:0] e_addr;
    logic [DW*NS-1:0] e_data;
    logic [NS-1:0]    e_racc;
    logic [1:0] e_state;
    logic [SW:0] e_link;
    bit in_cmd;
    model(v, mapped, acc, tmo, rc, mr, md);
    end_c      = rc + v.h;
    last_cmd   = acc ? 1 + v.a : rc - 1;
    resp_taken = 1'b0;
    for (int n = 0; n <= end_c; n++) begin
      @(posedge clk); #1;
      m_MCmd        = (n == 0 || v.pester) ? v.cmd : 3'd0;
      m_MAddr       = v.addr;
      m_MData       = v.data;
      m_MRespAccept = (n == end_c);
      s_SCmdAccept  = '0; s_SResp = '0; s_SData = '0;
      if (mapped) begin
        if (n == 1 + v.a) s_SCmdAccept[sel] = 1'b1;
        if (n >= 2 + v.a + v.r && !resp_taken) begin
          s_SResp[2*sel +: 2] = v.sresp;
          s_SData[8*sel +: 8] = v.sdata;
        end
      end
      @(negedge clk);
      if (tmo && n >= rc) tmo_exp = 1'b1;
      in_cmd = mapped && n >= 1 && n <= last_cmd;
      e_cmd = '0; e_addr = '0; e_data = '0; e_racc = '0;
      if (in_cmd) begin
        e_cmd[3*sel +: 3]  = v.cmd;
        e_addr[8*sel +: 8] = v.addr;
        e_data[8*sel +: 8] = v.data;
      end
      if (acc && !tmo && n == rc - 1) e_racc[sel] = 1'b1;
      e_state = (n == 0) ? 2'd0 : in_cmd ? 2'd1 : (n < rc) ? 2'd2 : 2'd3;
      e_link  = (mapped && n >= 1) ? (SW+1)'(sel + 1) : '0;
      chk("cmd_accept", 32'(m_SCmdAccept), 32'(n == 0));
      chk("link_state", 32'(link_state), 32'(e_state));
      chk("active_link", 32'(active_link), 32'(e_link));
      chk("s_MCmd", 32'(s_MCmd), 32'(e_cmd));
      chk("s_MAddr", 32'(s_MAddr), 32'(e_addr));
      chk("s_MData", 32'(s_MData), 32'(e_data));
      chk("s_MRespAccept", 32'(s_MRespAccept), 32'(e_racc));
      chk("m_SResp", 32'(m_SResp), (n >= rc) ? 32'(er) : 0);
      chk("m_SData", 32'(m_SData), (n >= rc) ? 32'(ed) : 0);
      chk("tmo_flag", 32'(tmo_flag), 32'(tmo_exp));
      if (mapped && s_MRespAccept[sel]) resp_taken = 1'b1;
    end
    @(posedge clk); #1;
    zero_inputs();
    @(negedge clk);
    check_idle("post_txn");
  endtask

  initial begin
    vec_t v;
    bit mp, ac, tm;
    int rc;
    logic [1:0] pr;
    logic [7:0] pd;

    tbl[0]  = mk(3'd2, 8'h85, 8'h00, 0, 2,  2'b01, 8'h3C, 0,  0, 2'b01, 8'h3C);
    tbl[1]  = mk(3'd1, 8'h10, 8'hA5, 0, 0,  2'b01, 8'h00, 1,  0, 2'b01, 8'h00);
    tbl[2]  = mk(3'd2, 8'hC0, 8'h00, 0, 0,  2'b01, 8'h00, 0,  0, 2'b11, 8'h00);
    tbl[3]  = mk(3'd2, 8'h40, 8'h00, 0, 20, 2'b01, 8'hEE, 15, 0, 2'b11, 8'h00);
    tbl[4]  = mk(3'd2, 8'h05, 8'h00, 1, 1,  2'b01, 8'h77, 0,  0, 2'b01, 8'h77);
    tbl[5]  = mk(3'd1, 8'h88, 8'h5A, 0, 0,  2'b01, 8'h11, 5,  1, 2'b01, 8'h11);
    tbl[6]  = mk(3'd3, 8'h00, 8'h00, 0, 0,  2'b01, 8'h00, 0,  0, 2'b11, 8'h00);
    tbl[7]  = mk(3'd2, 8'h41, 8'h00, 7, 0,  2'b01, 8'h42, 0,  0, 2'b01, 8'h42);
    tbl[8]  = mk(3'd2, 8'h42, 8'h00, 8, 1,  2'b01, 8'h43, 0,  0, 2'b11, 8'h00);
    tbl[9]  = mk(3'd2, 8'h43, 8'h00, 9, 0,  2'b01, 8'h44, 2,  0, 2'b11, 8'h00);
    tbl[10] = mk(3'd2, 8'h02, 8'h00, 0, 0,  2'b11, 8'h99, 0,  0, 2'b11, 8'h99);

    rst_n = 1'b0;
    zero_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i], tbl[i].exp_resp, tbl[i].exp_data);

    // Reset while the transaction sits in WAIT.
    @(posedge clk); #1;
    m_MCmd = 3'd2; m_MAddr = 8'h00;
    @(negedge clk);
    chk("rst_wait accept", 32'(m_SCmdAccept), 1);
    @(posedge clk); #1;
    m_MCmd = 3'd0; s_SCmdAccept[0] = 1'b1;
    @(negedge clk);
    chk("rst_wait cmd", 32'(link_state), 1);
    @(posedge clk); #1;
    s_SCmdAccept = '0;
    @(negedge clk);
    chk("rst_wait wait", 32'(link_state), 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tmo_exp = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    chk("after_reset s_MAddr", 32'(s_MAddr), 0);
    run_txn(tbl[4], tbl[4].exp_resp, tbl[4].exp_data);

    for (int i = 0; i < 30; i++) begin
      v.cmd = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                          : ($urandom_range(0, 1) ? 3'd1 : 3'd2);
      v.addr   = 8'($urandom);
      v.data   = 8'($urandom);
      v.a      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 10)) : int'($urandom_range(0, 3));
      v.r      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 4));
      v.sresp  = $urandom_range(0, 1) ? 2'b01 : 2'b11;
      v.sdata  = 8'($urandom);
      v.h      = int'($urandom_range(0, 3));
      v.pester = ($urandom_range(0, 3) == 0);
      model(v, mp, ac, tm, rc, pr, pd);
      run_txn(v, pr, pd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tree_link_n.md
# tree_link_n

Parametrised 1-master to N-slave OCP-style command/response router for the 50 MHz link domain. It replaces the fixed three-slave tree (uart to linebuffer, clock/reset and debugger) with a configurable slave count and data/address widths. It adds address decode, an error response for unmapped slaves, and a per-transaction timeout. Only one transaction is in flight at a time; the debug outputs `active_link` and `link_state` are kept.

## Interface
Parameters:
- `NUM_SLV`, 4: number of slave ports, 1..2^SEL_W.
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `SEL_W`, 2: slave select = `m_MAddr[ADDR_W-1 -: SEL_W]`.
- `TMO_CYC`, 255: cycles allowed in CMD+WAIT before abort, ≥2.

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- `clk`  in  1  link clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `m_MCmd`  in  3  master command: 000 IDLE, 001 WR, 010 RD.
- `m_MAddr`  in  ADDR_W  master address.
- `m_MData`  in  DATA_W  master write data.
- `m_SCmdAccept`  out  1  command accepted.
- `m_SData`  out  DATA_W  read data.
- `m_SResp`  out  2  response: 00 NULL, 01 DVA, 11 ERR.
- `m_MRespAccept`  in  1  master takes the response.
- `s_MCmd`  out  3*NUM_SLV  per-slave command, slave k at `[3k+:3]`.
- `s_MAddr`  out  ADDR_W*NUM_SLV  per-slave address.
- `s_MData`  out  DATA_W*NUM_SLV  per-slave write data.
- `s_SCmdAccept`  in  NUM_SLV  per-slave accept.
- `s_SData`  in  DATA_W*NUM_SLV  per-slave read data.
- `s_SResp`  in  2*NUM_SLV  per-slave response.
- `s_MRespAccept`  out  NUM_SLV  per-slave response accept.
- `active_link`  out  SEL_W+1  0 = idle, k+1 = slave k active.
- `link_state`  out  2  00 IDLE, 01 CMD, 10 WAIT, 11 RESP.
- `tmo_flag`  out  1  sticky: a timeout has occurred since reset.

## Operation
- **IDLE**
  - `m_SCmdAccept = (state==IDLE) && m_MCmd!=IDLE`, combinational.
  - On accept, latch cmd, addr, data and sel.
  - If `sel < NUM_SLV`, go to CMD.
  - Otherwise go to RESP with ERR, data 0, and `active_link` 0.
  - Reserved `m_MCmd` codes (not WR or RD) are treated like unmapped: ERR.
- **CMD**
  - Drive the latched cmd, addr and data on slave `sel` only.
  - Every other slave sees MCmd=IDLE; its addr and data are 0.
  - On `s_SCmdAccept[sel]`, go to WAIT.
- **WAIT**
  - Slave `sel` MCmd = IDLE.
  - When `s_SResp[sel] != NULL`: assert `s_MRespAccept[sel]` combinationally that cycle, capture SResp and SData, then go to RESP.
- **RESP**
  - Drive the captured `m_SResp` and `m_SData`, held until `m_MRespAccept`, then go to IDLE.
- **Writes** also return a response; the slave's DVA is passed through.
- **Timeout**
  - An 8+ bit counter clears on entry to CMD and increments in CMD and WAIT.
  - When it reaches `TMO_CYC` before the accept or response: drop the slave MCmd, go to RESP with ERR and data 0, and set `tmo_flag`.
  - A late slave response is never accepted; `s_MRespAccept[sel]` stays 0 outside WAIT.
- `s_MRespAccept` is 0 for all non-selected slaves at all times.
- `active_link` is `sel+1` in CMD, WAIT and RESP for mapped transactions, otherwise 0.

## Timing
- **Reset values:** all outputs 0. This means every MCmd IDLE, SResp NULL, accepts 0, state IDLE, `tmo_flag` 0.
- **Reset mid-transaction:** abandon it and return to IDLE on the next edge. Slave and master outputs are 0 in the cycle after reset is sampled.
- **Minimum read/write latency:** master command accepted at T; slave MCmd at T+1 and accepted at T+1; WAIT at T+2; slave SResp at T+2; `m_SResp` valid at T+3.
- **Unmapped latency:** accept at T, ERR on `m_SResp` at T+1.
- **Back-to-back:** the next master command is accepted no earlier than the cycle after `m_MRespAccept`. That is one IDLE cycle minimum; commands are never accepted in RESP.
- **Timeout:** with a slave that never accepts, ERR appears on `m_SResp` TMO_CYC+1 cycles after CMD entry.
- **Simultaneous accept and timeout tick:** the accept or response wins.

## Structure
- `tree_link_pkg` holds:
  - MCmd encodings IDLE/WR/RD;
  - SResp encodings NULL/DVA/ERR;
  - the state encoding IDLE/CMD/WAIT/RESP, whose values are the `link_state` values.
- Sub-module `tree_link_tmo`: timeout counter with clear, enable and `expired` outputs, parametrised by `TMO_CYC`.
- The main FSM, decode, capture registers and per-slave output fan-out live in `tree_link_n`.

## Test plan
- **Read, slave 2 (NUM_SLV=4):** RD, addr 0x85, 1-cycle slave accept, response DVA with 0x3C after 3 cycles. Expect: `s_MCmd[2]`=RD with addr 0x85; `m_SData`=0x3C, `m_SResp`=01; `active_link`=3; `link_state` sequence 01,10,…,11,00.
- **Write, slave 0:** WR, addr 0x10, data 0xA5. Expect: slave 0 sees 0xA5; the master gets DVA; `s_MCmd` of slaves 1–3 stays IDLE throughout.
- **Unmapped (NUM_SLV=3):** RD to 0xC0. Expect: accepted at T; `m_SResp`=11 and data 0 at T+1; no slave MCmd ever non-IDLE.
- **Timeout (TMO_CYC=8):** slave 1 never asserts SResp. Expect: ERR after the limit, `tmo_flag`=1; a later response from slave 1 is not accepted; the next transaction to slave 0 completes normally.
- **Held response:** the master holds `m_MRespAccept` low for 5 cycles. Expect: `m_SResp`/`m_SData` stable and a new `m_MCmd` not accepted during that time.
- **Reset in WAIT:** deassert `rst_n` for one cycle. Expect: all outputs 0 next cycle; the FSM is in IDLE; the following command proceeds normally.
